// File: rtl/kt_seq_pkg.sv
// rtl/kt_seq_pkg.sv - shared types and constants for the command sequencer
// Purpose: sequencer state enum, positive-acknowledge byte and err_code encodings.
// Ports: none (package).
package kt_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_SENT = 3'd2,
    WAIT_RESP = 3'd3,
    NEXT      = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } seq_state_t;

  localparam logic [7:0] POS_ACK     = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

endpackage

// File: rtl/resp_timer.sv
// rtl/resp_timer.sv - 32-bit response timeout counter
// Purpose: counts cycles while enabled; flags the last allowed cycle of the window.
// Ports:
//   clk     - clock, all logic on posedge
//   rst     - synchronous active-high reset (count -> 0)
//   clear   - synchronous clear of the count
//   enable  - increment the count this cycle
//   expired - high in the enabled cycle where count == TIMEOUT-1
module resp_timer #(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= 32'd0;
    end else if (enable) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign expired = enable && (r_count == (TIMEOUT - 32'd1));

endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - issues a table of 16-bit commands and checks each response byte
// Purpose: holds a DEPTH x 16 command table; on start sends num_cmds entries in order,
//   waiting for cmd_sent and an ack byte after each. Optional feature macro: SEQ_RETRY_EN
//   (one retry per command on timeout or negative ack).
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data       - command-table write port (accepted in every state)
//   num_cmds, start             - command count (sampled on start), start pulse
//   cmd, send_cmd               - command word and one-cycle send strobe
//   cmd_sent, resp_rdy, resp    - handshake from the remote link
//   busy, done, err             - status; done/err sticky until next accepted start
//   cmd_idx, err_code           - current table index; 01 timeout, 10 negative ack
module cmd_sequencer
  import kt_seq_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] RESP_TIMEOUT = 32'd50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [15:0]                wr_data,
  input  logic [$clog2(DEPTH):0]     num_cmds,
  input  logic                       start,
  output logic [15:0]                cmd,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH)-1:0]   cmd_idx,
  output logic [1:0]                 err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;

  logic [15:0]     r_table [DEPTH];
  logic [15:0]     r_cmd;
  logic [AW-1:0]   r_idx;
  logic [NW-1:0]   r_num;
  logic            r_done;
  logic            r_err;
  logic [1:0]      r_err_code;

  logic            w_start_ok;
  logic            w_load_cmd;
  logic [AW-1:0]   w_load_idx;
  logic            w_idx_inc;
  logic            w_set_done;
  logic            w_set_err;
  logic            w_fail;
  logic [1:0]      w_fail_code;
  logic            w_last;
  logic            w_expired;
  logic            w_tmr_clear;
  logic            w_tmr_en;

`ifdef SEQ_RETRY_EN
  logic            r_retry;
  logic            w_retry_set;
`endif

  // Table has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Counter only runs in WAIT_RESP; any other state holds it at zero, which
  // covers the clear on cmd_sent acceptance.
  assign w_tmr_en    = (r_state == WAIT_RESP);
  assign w_tmr_clear = (r_state != WAIT_RESP);

  resp_timer #(
    .TIMEOUT (RESP_TIMEOUT)
  ) u_resp_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .expired (w_expired)
  );

  assign w_last = ({1'b0, r_idx} == (r_num - NW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_load_cmd  = 1'b0;
    w_load_idx  = r_idx;
    w_idx_inc   = 1'b0;
    w_set_done  = 1'b0;
    w_set_err   = 1'b0;
    w_fail      = 1'b0;
    w_fail_code = ERR_NONE;
`ifdef SEQ_RETRY_EN
    w_retry_set = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok = 1'b1;
          if (num_cmds == '0) begin
            w_state_nxt = DONE;
            w_set_done  = 1'b1;
          end else begin
            w_state_nxt = SEND;
            w_load_cmd  = 1'b1;
            w_load_idx  = '0;
          end
        end
      end
      SEND:      w_state_nxt = WAIT_SENT;
      WAIT_SENT: begin
        if (cmd_sent) begin
          w_state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response in the expiry cycle takes priority over the timeout.
        if (resp_rdy) begin
          if (resp == POS_ACK) begin
            w_state_nxt = NEXT;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = ERR_NACK;
          end
        end else if (w_expired) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end
      end
      NEXT: begin
        if (w_last) begin
          w_state_nxt = DONE;
          w_set_done  = 1'b1;
        end else begin
          w_state_nxt = SEND;
          w_idx_inc   = 1'b1;
          w_load_cmd  = 1'b1;
          w_load_idx  = r_idx + AW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (w_fail) begin
`ifdef SEQ_RETRY_EN
      if (!r_retry) begin
        w_state_nxt = SEND;
        w_load_cmd  = 1'b1;
        w_retry_set = 1'b1;
      end else begin
        w_state_nxt = ERR;
        w_set_err   = 1'b1;
      end
`else
      w_state_nxt = ERR;
      w_set_err   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= 16'h0000;
      r_idx      <= '0;
      r_num      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_start_ok) begin
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
        r_idx      <= '0;
        r_num      <= num_cmds;
      end
      if (w_idx_inc) begin
        r_idx <= r_idx + AW'(1);
      end
      // cmd is captured once on entry to SEND, so later table writes cannot
      // disturb a command that is in flight.
      if (w_load_cmd) begin
        r_cmd <= r_table[w_load_idx];
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
      end
    end
  end

`ifdef SEQ_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retry <= 1'b0;
    end else if (w_start_ok || (w_state_nxt == NEXT)) begin
      r_retry <= 1'b0;
    end else if (w_retry_set) begin
      r_retry <= 1'b1;
    end
  end
`endif

  assign cmd      = r_cmd;
  assign send_cmd = (r_state == SEND);
  assign busy     = (r_state != IDLE) && (r_state != DONE) && (r_state != ERR);
  assign done     = r_done;
  assign err      = r_err;
  assign cmd_idx  = r_idx;
  assign err_code = r_err_code;

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: command-table entries (power of 2, 2..64).
REQ-002 SHALL have parameter RESP_TIMEOUT, default 32'd50_000_000: max clk cycles waiting for a response byte.
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports wr_en / wr_addr / wr_data  input  1 / $clog2(DEPTH) / 16  command-table write port.
REQ-006 SHALL have port num_cmds  input  $clog2(DEPTH)+1  number of commands to issue; sampled on start.
REQ-007 SHALL have port start  input  1  single-cycle pulse that begins a sequence.
REQ-008 SHALL have ports cmd / send_cmd  output  16 / 1  command word and one-cycle send strobe to RemoteComm.
REQ-009 SHALL have ports cmd_sent / resp_rdy / resp  input  1 / 1 / 8  handshake inputs from RemoteComm.
REQ-010 SHALL have ports busy / done / err  output  1 each  status; done and err are sticky until the next start.
REQ-011 SHALL have ports cmd_idx / err_code  output  $clog2(DEPTH) / 2  current index; error cause (01 timeout, 10 negative ack).

Function
REQ-012 SHALL implement states IDLE, SEND, WAIT_SENT, WAIT_RESP, NEXT, DONE, ERR.
REQ-013 IDLE: start with num_cmds>0 SHALL clear done/err, set cmd_idx=0, latch num_cmds, and go to SEND.
REQ-014 start with num_cmds==0 SHALL go directly to DONE (done=1 next cycle, send_cmd never asserted).
REQ-015 SEND SHALL drive cmd=table[cmd_idx], pulse send_cmd for exactly one cycle, and enter WAIT_SENT.
REQ-016 cmd SHALL remain stable from the send_cmd cycle until cmd_sent is seen.
REQ-017 WAIT_SENT SHALL move to WAIT_RESP on cmd_sent=1 and clear the timeout counter.
REQ-018 WAIT_RESP SHALL increment a 32-bit counter each cycle; resp_rdy with resp==8'hA5 SHALL go to NEXT.
REQ-019 resp_rdy with resp!=8'hA5 SHALL go to ERR with err_code=2'b10.
REQ-020 counter==RESP_TIMEOUT-1 without resp_rdy SHALL go to ERR with err_code=2'b01; resp_rdy in that same cycle wins over timeout.
REQ-021 NEXT SHALL go to DONE if cmd_idx==num_cmds-1; otherwise it SHALL increment cmd_idx and return to SEND (min 1 idle cycle between send_cmd pulses).
REQ-022 DONE and ERR SHALL assert done or err respectively, deassert busy, and return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-024 start while busy SHALL be ignored.
REQ-025 Table writes SHALL be accepted in every state; a write to the entry currently being sent SHALL NOT alter cmd until the next SEND.
REQ-026 resp_rdy outside WAIT_RESP SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE, cmd=16'h0000, send_cmd=0, busy=0, done=0, err=0, err_code=0, cmd_idx=0, counter=0, including mid-sequence.
REQ-028 Table contents SHALL NOT be cleared by rst.

Configuration
REQ-029 With SEQ_RETRY_EN defined, the first timeout or negative ack on a given command SHALL re-enter SEND for the same cmd_idx; a second failure goes to ERR.
REQ-030 Retry SHALL be tracked by a 1-bit flag cleared on entry to NEXT and on start.
REQ-031 Without SEQ_RETRY_EN, any failure SHALL go to ERR immediately and no retry flag SHALL exist.

Structure
REQ-032 Package kt_seq_pkg SHALL hold the state enum, POS_ACK=8'hA5, and err_code encodings.
REQ-033 The timeout counter SHALL be a sub-module resp_timer (clear, enable, expired).
REQ-034 The table SHALL be a DEPTH x 16 register array inside cmd_sequencer.

Verification
REQ-035 Load {16'h2000, 16'h4BF1}, num_cmds=2, start; ack A5 after each cmd_sent -> two send_cmd pulses with 2000 then 4BF1; done=1, err=0.
REQ-036 num_cmds=0, start -> done=1 the next cycle, send_cmd never asserted.
REQ-037 RESP_TIMEOUT=100, never respond -> err=1, err_code=01 exactly 100 cycles after cmd_sent (no macro); with SEQ_RETRY_EN, second send_cmd first, then err.
REQ-038 Respond with 8'h5A to cmd 0 -> err=1, err_code=10, cmd_idx=0.
REQ-039 Assert rst during WAIT_RESP of cmd 1 -> all outputs at reset values next cycle; restart runs from cmd_idx 0 with the table intact.
REQ-040 Pulse start during busy and resp_rdy in IDLE -> no state change, no extra send_cmd.
